// File: rtl/sram_arbiter_rmw.sv
// Two-requester arbiter in front of a single-ported-per-direction SRAM.
// Fetch and LSU share it round-robin; sub-word stores become read-modify-write.
module sram_arbiter_rmw #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W/8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_wack,
  output logic [ADDR_W-1:0] sram_addr_a,
  output logic [DATA_W-1:0] sram_din_a,
  output logic              sram_we_a,
  output logic [ADDR_W-1:0] sram_addr_b,
  output logic              sram_en_b,
  input  logic [DATA_W-1:0] sram_dout_b
);

  typedef enum logic [1:0] {IDLE, RD_RESP, RMW_MERGE, WR_ACK} state_t;

  state_t            state;
  logic              last_d;   // 1: D was granted last
  logic              owner_d;  // read response belongs to D
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic              grant_d, grant_i, idle;
  logic              be_full, be_zero;
  logic [DATA_W-1:0] merged;

  assign grant_d = d_valid & (~i_valid | ~last_d);
  assign grant_i = i_valid & ~grant_d;
  // Gate with rst_n so nothing is accepted while reset is held.
  assign idle    = (state == IDLE) & rst_n;
  assign i_ready = idle & grant_i;
  assign d_ready = idle & grant_d;

  assign be_full = &d_be;
  assign be_zero = ~|d_be;

  for (genvar k = 0; k < BE_W; k++) begin : g_merge
    assign merged[k*8 +: 8] = be_q[k] ? wdata_q[k*8 +: 8] : sram_dout_b[k*8 +: 8];
  end

  // Port B reads for fetches, loads and the first half of a partial store.
  assign sram_en_b   = i_ready | (d_ready & (~d_we | (~be_full & ~be_zero)));
  assign sram_addr_b = d_ready ? d_addr : i_addr;

  assign sram_we_a   = (d_ready & d_we & be_full) | (state == RMW_MERGE);
  assign sram_addr_a = (state == RMW_MERGE) ? addr_q : d_addr;
  assign sram_din_a  = (state == RMW_MERGE) ? merged : d_wdata;

  assign i_rvalid = (state == RD_RESP) & ~owner_d;
  assign d_rvalid = (state == RD_RESP) & owner_d;
  assign i_rdata  = sram_dout_b;
  assign d_rdata  = sram_dout_b;
  assign d_wack   = (state == WR_ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      owner_d <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_ready) begin
            last_d  <= 1'b0;
            owner_d <= 1'b0;
            state   <= RD_RESP;
          end else if (d_ready) begin
            last_d <= 1'b1;
            if (!d_we) begin
              owner_d <= 1'b1;
              state   <= RD_RESP;
            end else if (be_full || be_zero) begin
              state <= WR_ACK;
            end else begin
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              be_q    <= d_be;
              state   <= RMW_MERGE;
            end
          end
        end
        RD_RESP:   state <= IDLE;
        RMW_MERGE: state <= WR_ACK;
        WR_ACK:    state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule
